// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB colour fader: channel width, FSM state
// encoding and the packed RGB triple used for colour registers.
package rgb_pkg;

    localparam int unsigned COLOR_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_t;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/rgb_fade_channel.sv
// One colour channel of the fader: saturating step of at most STEP toward
// the target. Purely combinational.
//   current    : present channel value
//   target     : value being faded toward
//   step_en    : apply one step this cycle
//   next_value : current moved toward target (or current when not stepping)
//   at_target  : current already equals target
module rgb_fade_channel
    import rgb_pkg::*;
#(
    parameter int unsigned STEP = 1
) (
    input  logic [COLOR_W-1:0] current,
    input  logic [COLOR_W-1:0] target,
    input  logic               step_en,
    output logic [COLOR_W-1:0] next_value,
    output logic               at_target
);

    localparam int unsigned DIFF_W = COLOR_W + 1;

    logic signed [DIFF_W-1:0] diff;
    logic        [DIFF_W-1:0] mag;
    logic        [COLOR_W-1:0] amt;

    // Step size is min(STEP, |diff|), so the result can never overshoot.
    always_comb begin
        diff       = $signed({1'b0, target}) - $signed({1'b0, current});
        mag        = diff[DIFF_W-1] ? $unsigned(-diff) : $unsigned(diff);
        amt        = (mag > DIFF_W'(STEP)) ? COLOR_W'(STEP) : mag[COLOR_W-1:0];
        at_target  = (diff == '0);
        next_value = current;
        if (step_en && !at_target) begin
            next_value = diff[DIFF_W-1] ? (current - amt) : (current + amt);
        end
    end

endmodule

// File: rtl/rgb_color_fader.sv
// Colour source for the PWM LED controller. Accepts a target colour over a
// valid/ready handshake and ramps the current colour toward it by at most
// STEP per channel on every (rate+1)-th sync pulse.
//   clk, rst              : clock, asynchronous active-high reset
//   sync                  : start-of-PWM-cycle pulse from the controller
//   target_r/g/b, rate    : new target colour and step divider
//   target_valid/ready    : handshake for the target
//   rcolor_o/gcolor_o/bcolor_o : current colour to the controller
//   busy                  : fade in progress
//   done                  : one-cycle pulse when the fade completes
module rgb_color_fader
    import rgb_pkg::*;
#(
    parameter int unsigned STEP   = 1,
    parameter int unsigned RATE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sync,
    input  logic [COLOR_W-1:0] target_r,
    input  logic [COLOR_W-1:0] target_g,
    input  logic [COLOR_W-1:0] target_b,
    input  logic               target_valid,
    output logic               target_ready,
    input  logic [RATE_W-1:0]  rate,
    output logic [COLOR_W-1:0] rcolor_o,
    output logic [COLOR_W-1:0] gcolor_o,
    output logic [COLOR_W-1:0] bcolor_o,
    output logic               busy,
    output logic               done
);

    state_t              state;
    rgb_t                cur_q;
    rgb_t                tgt_q;
    rgb_t                nxt;
    logic [RATE_W-1:0]   rate_q;
    logic [RATE_W-1:0]   tick_q;
    logic [2:0]          at_tgt;
    logic                all_at;
    logic                step_c;

    assign all_at = &at_tgt;
    // Completion has priority, so no step is requested once all channels match.
    assign step_c = (state == FADE) && sync && (tick_q == rate_q) && !all_at;

    rgb_fade_channel #(.STEP(STEP)) u_ch_r (
        .current    (cur_q.r),
        .target     (tgt_q.r),
        .step_en    (step_c),
        .next_value (nxt.r),
        .at_target  (at_tgt[0])
    );

    rgb_fade_channel #(.STEP(STEP)) u_ch_g (
        .current    (cur_q.g),
        .target     (tgt_q.g),
        .step_en    (step_c),
        .next_value (nxt.g),
        .at_target  (at_tgt[1])
    );

    rgb_fade_channel #(.STEP(STEP)) u_ch_b (
        .current    (cur_q.b),
        .target     (tgt_q.b),
        .step_en    (step_c),
        .next_value (nxt.b),
        .at_target  (at_tgt[2])
    );

    // FSM, handshake capture, sync-tick divider and colour registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cur_q  <= '0;
            tgt_q  <= '0;
            rate_q <= '0;
            tick_q <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (target_valid) begin
                        tgt_q  <= '{r: target_r, g: target_g, b: target_b};
                        rate_q <= rate;
                        tick_q <= '0;
                        state  <= FADE;
                    end
                end
                FADE: begin
                    if (all_at) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else if (sync) begin
                        if (tick_q == rate_q) begin
                            tick_q <= '0;
                            cur_q  <= nxt;
                        end else begin
                            tick_q <= tick_q + RATE_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rcolor_o     = cur_q.r;
    assign gcolor_o     = cur_q.g;
    assign bcolor_o     = cur_q.b;
    assign busy         = (state == FADE);
    assign target_ready = (state == IDLE) && !rst;

endmodule

// File: tb/tb_rgb_color_fader.sv
// Bench for rgb_color_fader: two instances (STEP=1 and STEP=16) share the
// colour/sync/rate inputs but have separate target_valid. A transaction-level
// model counts syncs since acceptance and moves colours toward the target.
module tb_rgb_color_fader;

    logic       clk;
    logic       rst;
    logic       sync;
    logic [7:0] tr, tg, tb;
    logic [7:0] rate;
    logic [1:0] tv;

    logic [7:0] rc [2];
    logic [7:0] gc [2];
    logic [7:0] bc [2];
    logic       ready [2];
    logic       busy [2];
    logic       done [2];

    int checks = 0;
    int errors = 0;

    // Reference model state, one entry per instance.
    int m_step [2] = '{1, 16};
    bit m_fade [2];
    bit m_done [2];
    int m_cur  [2][3];
    int m_tgt  [2][3];
    int m_rate [2];
    int m_syncs[2];

    rgb_color_fader #(.STEP(1), .RATE_W(8)) dut0 (
        .clk(clk), .rst(rst), .sync(sync),
        .target_r(tr), .target_g(tg), .target_b(tb),
        .target_valid(tv[0]), .target_ready(ready[0]), .rate(rate),
        .rcolor_o(rc[0]), .gcolor_o(gc[0]), .bcolor_o(bc[0]),
        .busy(busy[0]), .done(done[0])
    );

    rgb_color_fader #(.STEP(16), .RATE_W(8)) dut1 (
        .clk(clk), .rst(rst), .sync(sync),
        .target_r(tr), .target_g(tg), .target_b(tb),
        .target_valid(tv[1]), .target_ready(ready[1]), .rate(rate),
        .rcolor_o(rc[1]), .gcolor_o(gc[1]), .bcolor_o(bc[1]),
        .busy(busy[1]), .done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int move_toward(int c, int t, int s);
        if (t > c) return c + (((t - c) < s) ? (t - c) : s);
        if (t < c) return c - (((c - t) < s) ? (c - t) : s);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_fade[i]  = 0;
            m_done[i]  = 0;
            m_rate[i]  = 0;
            m_syncs[i] = 0;
            for (int c = 0; c < 3; c++) begin
                m_cur[i][c] = 0;
                m_tgt[i][c] = 0;
            end
        end
    endtask

    // Advance the model across one rising edge using the inputs now driven.
    task automatic model_edge();
        int tin[3];
        bit eq;
        if (rst) begin
            model_reset();
            return;
        end
        tin[0] = int'(tr); tin[1] = int'(tg); tin[2] = int'(tb);
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 0;
            eq = (m_cur[i][0] == m_tgt[i][0]) && (m_cur[i][1] == m_tgt[i][1]) &&
                 (m_cur[i][2] == m_tgt[i][2]);
            if (!m_fade[i]) begin
                if (tv[i]) begin
                    for (int c = 0; c < 3; c++) m_tgt[i][c] = tin[c];
                    m_rate[i]  = int'(rate);
                    m_syncs[i] = 0;
                    m_fade[i]  = 1;
                end
            end else if (eq) begin
                m_fade[i] = 0;
                m_done[i] = 1;
            end else if (sync) begin
                m_syncs[i]++;
                if (m_syncs[i] % (m_rate[i] + 1) == 0)
                    for (int c = 0; c < 3; c++)
                        m_cur[i][c] = move_toward(m_cur[i][c], m_tgt[i][c], m_step[i]);
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("red%0d", i),   32'(rc[i]),    32'(m_cur[i][0]));
            check($sformatf("green%0d", i), 32'(gc[i]),    32'(m_cur[i][1]));
            check($sformatf("blue%0d", i),  32'(bc[i]),    32'(m_cur[i][2]));
            check($sformatf("busy%0d", i),  32'(busy[i]),  32'(m_fade[i]));
            check($sformatf("done%0d", i),  32'(done[i]),  32'(m_done[i]));
            check($sformatf("ready%0d", i), 32'(ready[i]), 32'(!m_fade[i] && !rst));
        end
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // Three quiet cycles then one sync cycle, i.e. sync every 4 clk.
    task automatic sync_cycle();
        for (int k = 0; k < 4; k++) begin
            sync = (k == 3);
            cycle();
        end
        sync = 1'b0;
    endtask

    task automatic send(input logic [1:0] mask, input int r, input int g, input int b, input int rt);
        tr = 8'(r); tg = 8'(g); tb = 8'(b); rate = 8'(rt);
        tv = mask;
        cycle();
        tv = 2'b00;
    endtask

    task automatic wait_idle(input int i, input int budget);
        int n = 0;
        while (busy[i] && n < budget) begin
            sync_cycle();
            n++;
        end
        check($sformatf("idle_timeout%0d", i), 32'(busy[i]), 32'd0);
    endtask

    task automatic check_rgb(input string tag, input int i, input int r, input int g, input int b);
        check({tag, "_r"}, 32'(rc[i]), 32'(r));
        check({tag, "_g"}, 32'(gc[i]), 32'(g));
        check({tag, "_b"}, 32'(bc[i]), 32'(b));
    endtask

    initial begin
        rst = 1'b1; sync = 1'b0; tv = 2'b00;
        tr = '0; tg = '0; tb = '0; rate = '0;
        model_reset();
        @(negedge clk);
        check_all();
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        check("reset_ready0", 32'(ready[0]), 32'd1);

        // Up-ramp, STEP=1, rate 0.
        send(2'b01, 3, 1, 0, 0);
        sync_cycle(); check_rgb("up1", 0, 1, 1, 0);
        sync_cycle(); check_rgb("up2", 0, 2, 1, 0);
        sync_cycle(); check_rgb("up3", 0, 3, 1, 0);
        cycle();
        check("up_done", 32'(done[0]), 32'd1);
        check("up_ready", 32'(ready[0]), 32'd1);
        cycle();
        check("up_done_once", 32'(done[0]), 32'd0);

        // Saturating down-ramp, STEP=16.
        send(2'b10, 20, 200, 0, 0);
        wait_idle(1, 40);
        check_rgb("dn_start", 1, 20, 200, 0);
        send(2'b10, 0, 180, 0, 0);
        sync_cycle(); check_rgb("dn1", 1, 4, 184, 0);
        sync_cycle(); check_rgb("dn2", 1, 0, 180, 0);
        cycle();
        check("dn_done", 32'(done[1]), 32'd1);

        // Reset held three cycles mid-stream.
        rst = 1'b1;
        cycle(); cycle(); cycle();
        check_rgb("rst_hold", 0, 0, 0, 0);
        rst = 1'b0;
        cycle();
        check("rst_ready0", 32'(ready[0]), 32'd1);
        check("rst_ready1", 32'(ready[1]), 32'd1);

        // Rate divide: rate 2 steps on every third sync.
        send(2'b01, 2, 0, 0, 2);
        for (int k = 1; k <= 6; k++) begin
            sync_cycle();
            check($sformatf("rate_sync%0d", k), 32'(rc[0]), 32'(k / 3));
        end
        wait_idle(0, 4);

        // Target presented during a fade is ignored.
        send(2'b01, 10, 0, 0, 0);
        sync_cycle();
        check("hs_ready_busy", 32'(ready[0]), 32'd0);
        send(2'b01, 50, 50, 50, 0);
        wait_idle(0, 20);
        check_rgb("hs_orig", 0, 10, 0, 0);
        send(2'b01, 50, 50, 50, 0);
        check("hs_accept", 32'(busy[0]), 32'd1);
        wait_idle(0, 80);
        check_rgb("hs_final", 0, 50, 50, 50);

        // Target equal to current colour completes immediately.
        send(2'b01, 50, 50, 50, 0);
        check("eq_busy", 32'(busy[0]), 32'd1);
        cycle();
        check("eq_done", 32'(done[0]), 32'd1);
        check_rgb("eq_rgb", 0, 50, 50, 50);

        // Asynchronous reset mid-fade.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        send(2'b01, 20, 20, 20, 0);
        for (int k = 0; k < 7; k++) sync_cycle();
        check_rgb("ar_pre", 0, 7, 7, 7);
        #2 rst = 1'b1;
        #1;
        check_rgb("ar_now", 0, 0, 0, 0);
        check("ar_busy", 32'(busy[0]), 32'd0);
        check("ar_done", 32'(done[0]), 32'd0);
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;
        cycle();
        check("ar_ready", 32'(ready[0]), 32'd1);
        check("ar_idle", 32'(busy[0]), 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 2500; n++) begin
            bit big;
            rst  = ($urandom_range(0, 399) == 0);
            sync = ($urandom_range(0, 2) == 0);
            tv   = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
            big  = ($urandom_range(0, 9) == 0);
            tr   = big ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 24));
            tg   = big ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 24));
            tb   = big ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 24));
            rate = 8'($urandom_range(0, 2));
            cycle();
        end
        rst = 1'b0; sync = 1'b0; tv = 2'b00;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_color_fader.md
Name: rgb_color_fader

Overview:
- Upstream colour source for rgb_led_controller8. Drives its rcolor_i/gcolor_i/bcolor_i inputs.
- Accepts a target RGB colour through a valid/ready handshake.
- Ramps the current colour toward the target by at most STEP per channel, once every (rate+1) PWM cycles.
- Counts PWM cycles on the controller's sync output, so colour changes line up with the controller's own per-cycle colour latching.

Parameters:
- STEP, 1, maximum per-channel change applied at each step event (1..255).
- RATE_W, 8, width of the rate input and of the internal sync-tick counter.

Ports:
- clk  input  1  system clock; same clock as the PWM controller.
- rst  input  1  reset, asynchronous, active-high.
- sync  input  1  one-clk-wide pulse from the PWM controller at the start of each PWM cycle.
- target_r  input  8  target red.
- target_g  input  8  target green.
- target_b  input  8  target blue.
- target_valid  input  1  target_* and rate are valid.
- target_ready  output  1  fader can accept a new target.
- rate  input  RATE_W  number of extra sync pulses between steps; 0 means step on every sync.
- rcolor_o  output  8  current red; connects to rcolor_i.
- gcolor_o  output  8  current green; connects to gcolor_i.
- bcolor_o  output  8  current blue; connects to bcolor_i.
- busy  output  1  a fade is in progress.
- done  output  1  one-clk pulse when the fade completes.

Behaviour:
- Reset state: state=IDLE, rcolor_o=gcolor_o=bcolor_o=0, done=0, tick counter=0, target registers=0.
- All state is cleared asynchronously on rst; rst mid-fade aborts the fade with no completion pulse.
- target_ready = (state==IDLE) and not rst. busy = (state==FADE).

State machine (IDLE, FADE):
- IDLE, target_valid=1: on that clk edge, latch target_r/g/b and rate, clear the tick counter, go to FADE. target_ready drops in the next cycle.
- IDLE, target_valid=0: hold. Outputs are static.
- FADE, all three outputs equal the latched targets: go to IDLE; done=1 for exactly the following cycle.
  - This equality check has priority over stepping.
  - A target equal to the current colour therefore completes with done one cycle after acceptance.
- FADE, sync=1 and tick counter==latched rate: step event. Tick counter clears to 0.
- FADE, sync=1 and tick counter!=latched rate: tick counter increments.
- FADE, sync=0: hold.
- target_valid while in FADE is ignored (ready=0). No queueing and no retargeting mid-fade.

Step arithmetic (per channel, independent):
- Compute diff = target - current using 9-bit signed arithmetic.
- diff>0: current += min(STEP, diff).
- diff<0: current -= min(STEP, -diff).
- diff==0: unchanged.
- Results never overshoot, wrap, underflow or overflow. Channels reach their targets at different steps; completion requires all three equal.

Timing:
- Outputs are registered and change only on step events, i.e. in the same edge as a sync pulse.
- The PWM controller latches its colour on the rising edge of sync, so a new value is picked up at its next cycle start. Worst-case added latency is one PWM cycle, which is accepted.

Decomposition:
- Shared package rgb_pkg: COLOR_W=8, FSM state encoding (IDLE=1'b0, FADE=1'b1).
- One natural sub-module, rgb_fade_channel, instantiated three times.
  - Inputs: current, target, step_en.
  - Outputs: next value, at_target.
  - Contains the saturating step toward target.
- The top level holds the FSM, handshake, tick counter and target registers.

Test Plan:
- Reset: assert rst for 3 cycles mid-stream -> outputs 0, busy 0, done 0, target_ready 1 after release.
- Up-ramp (STEP=1, rate=0, sync every 4 clk): target (3,1,0) -> colour sequence (1,1,0), (2,1,0), (3,1,0) on successive syncs; done high one cycle after reaching (3,1,0), then target_ready=1.
- Saturating down-ramp (STEP=16): start at (20,200,0), target (0,180,0) -> red 20→4→0, green 200→184→180, blue stays 0; no wrap; done after the 2nd step.
- Rate divide: STEP=1, rate=2, target (2,0,0) from 0 -> red changes only on the 3rd and 6th sync pulses after acceptance.
- Busy handshake: assert target_valid with (50,50,50) during a fade -> target_ready=0, request ignored; the original fade completes; the re-presented target is accepted in IDLE. Separately, target equal to current -> done one cycle after acceptance, no output change.
- rst asserted asynchronously mid-fade at colour (7,7,7) -> outputs 0 immediately, no done pulse, IDLE on release.
